// File: rtl/sky130_sram_1rw1r_param_if.sv
// Bus bundle for the 1RW + 1R SRAM.
// master: drives chip selects, write enable, masks, addresses and write data.
// slave : the SRAM; returns read data, busy (init fill in progress) and the
//         same-address write/read collision pulse.
interface sky130_sram_1rw1r_param_if #(
  parameter int NUM_WMASKS = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 9
);
  logic                  csb0;
  logic                  web0;
  logic [NUM_WMASKS-1:0] wmask0;
  logic                  spare_wen0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] din0;
  logic [DATA_WIDTH-1:0] dout0;
  logic                  csb1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] dout1;
  logic                  busy;
  logic                  collision;

  modport master (
    output csb0, web0, wmask0, spare_wen0, addr0, din0, csb1, addr1,
    input  dout0, dout1, busy, collision
  );

  modport slave (
    input  csb0, web0, wmask0, spare_wen0, addr0, din0, csb1, addr1,
    output dout0, dout1, busy, collision
  );
endinterface

// File: rtl/sky130_sram_1rw1r_param.sv
// Behavioural 1RW + 1R SRAM with lane write masks, spare columns, optional
// output register and an optional zero-fill after reset.
// Ports:
//   clk0  - single clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - slave side of sky130_sram_1rw1r_param_if (port 0 RW, port 1 R,
//           busy, collision)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_INIT  | zero-filling word clr_cnt each cycle, requests ignored
// ST_READY | normal operation on both ports
module sky130_sram_1rw1r_param #(
  parameter int NUM_WMASKS     = 4,
  parameter int WRITE_SIZE     = 2,
  parameter int NUM_SPARE_COLS = 1,
  parameter int ADDR_WIDTH     = 5,
  parameter int OUT_REG        = 0,
  parameter int INIT_CLEAR     = 1
) (
  input logic clk0,
  input logic rst_n,
  sky130_sram_1rw1r_param_if.slave bus
);
  localparam int LANE_BITS  = NUM_WMASKS * WRITE_SIZE;
  localparam int DATA_WIDTH = LANE_BITS + NUM_SPARE_COLS;
  localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATA_WIDTH-1:0] dout0_q, dout0_d, dout1_q, dout1_d;
  logic [DATA_WIDTH-1:0] pipe0_q, pipe0_d, pipe1_q, pipe1_d;
  logic                  pv0_q, pv0_d, pv1_q, pv1_d;
  logic                  collision_q, collision_d;

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic                  ready, rd0, rd1, wr0;
  logic [DATA_WIDTH-1:0] bit_we, wdata;

  always_comb begin
    ready = (state_q == ST_READY);
    rd0   = ready & ~bus.csb0 & bus.web0;
    wr0   = ready & ~bus.csb0 & ~bus.web0;
    rd1   = ready & ~bus.csb1;

    // Expand lane masks to per-bit enables; spare bits ride on spare_wen0.
    bit_we = '0;
    for (int i = 0; i < NUM_WMASKS; i++) begin
      bit_we[i*WRITE_SIZE +: WRITE_SIZE] = {WRITE_SIZE{bus.wmask0[i]}};
    end
    for (int b = LANE_BITS; b < DATA_WIDTH; b++) begin
      bit_we[b] = bus.spare_wen0;
    end
    wdata = (mem[bus.addr0] & ~bit_we) | (bus.din0 & bit_we);

    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (!ready) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (&clr_cnt_q) state_d = ST_READY;
    end

    collision_d = wr0 & rd1 & (bus.addr0 == bus.addr1);

    // Read stage: the array is sampled before this edge's write lands, so
    // port 1 sees the pre-write word on a same-address collision.
    pipe0_d = rd0 ? mem[bus.addr0] : pipe0_q;
    pipe1_d = rd1 ? mem[bus.addr1] : pipe1_q;
    pv0_d   = rd0;
    pv1_d   = rd1;

    if (OUT_REG != 0) begin
      // Output stage advances every cycle; holds when nothing was read.
      dout0_d = pv0_q ? pipe0_q : dout0_q;
      dout1_d = pv1_q ? pipe1_q : dout1_q;
    end else begin
      dout0_d = pipe0_d;
      dout1_d = pipe1_d;
    end
  end

  always_ff @(posedge clk0 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= (INIT_CLEAR != 0) ? ST_INIT : ST_READY;
      clr_cnt_q   <= '0;
      dout0_q     <= '0;
      dout1_q     <= '0;
      pipe0_q     <= '0;
      pipe1_q     <= '0;
      pv0_q       <= 1'b0;
      pv1_q       <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      dout0_q     <= dout0_d;
      dout1_q     <= dout1_d;
      pipe0_q     <= pipe0_d;
      pipe1_q     <= pipe1_d;
      pv0_q       <= pv0_d;
      pv1_q       <= pv1_d;
      collision_q <= collision_d;
    end
  end

  // The array itself has no reset. With INIT_CLEAR=0 port 0 must be kept
  // deselected while rst_n is low, since READY is already in force then.
  always_ff @(posedge clk0) begin
    if (!ready) begin
      mem[clr_cnt_q] <= '0;
    end else if (wr0) begin
      mem[bus.addr0] <= wdata;
    end
  end

  assign bus.dout0     = dout0_q;
  assign bus.dout1     = dout1_q;
  assign bus.busy      = ~ready;
  assign bus.collision = collision_q;
endmodule

// File: tb/tb_sky130_sram_1rw1r_param.sv
module tb_sky130_sram_1rw1r_param;
  logic clk0 = 1'b0;
  logic rst_n;
  always #5 clk0 = ~clk0;

  sky130_sram_1rw1r_param_if bus ();
  sky130_sram_1rw1r_param_if bus2 ();

  sky130_sram_1rw1r_param dut (.clk0(clk0), .rst_n(rst_n), .bus(bus));
  sky130_sram_1rw1r_param #(.OUT_REG(1)) dut2 (.clk0(clk0), .rst_n(rst_n), .bus(bus2));

  assign bus2.csb0       = bus.csb0;
  assign bus2.web0       = bus.web0;
  assign bus2.wmask0     = bus.wmask0;
  assign bus2.spare_wen0 = bus.spare_wen0;
  assign bus2.addr0      = bus.addr0;
  assign bus2.din0       = bus.din0;
  assign bus2.csb1       = bus.csb1;
  assign bus2.addr1      = bus.addr1;

  int vectors = 0;
  int errs    = 0;

  // Reference model: word array plus expected outputs of both instances.
  logic [8:0] m [32];
  logic [8:0] e0, e1, e20, e21, pd0, pd1;
  logic       pv0, pv1, ec;
  int         fill_left;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("dout0", bus.dout0, e0);
    chk("dout1", bus.dout1, e1);
    chk("collision", {8'b0, bus.collision}, {8'b0, ec});
    chk("busy", {8'b0, bus.busy}, {8'b0, (rst_n == 1'b0) || (fill_left > 0)});
    chk("r2_dout0", bus2.dout0, e20);
    chk("r2_dout1", bus2.dout1, e21);
    chk("r2_collision", {8'b0, bus2.collision}, {8'b0, ec});
  endtask

  task automatic model_reset();
    e0 = '0; e1 = '0; e20 = '0; e21 = '0; ec = 1'b0;
    pv0 = 1'b0; pv1 = 1'b0; fill_left = 32;
  endtask

  task automatic idle();
    bus.csb0 = 1'b1; bus.web0 = 1'b1; bus.wmask0 = '0; bus.spare_wen0 = 1'b0;
    bus.addr0 = '0; bus.din0 = '0; bus.csb1 = 1'b1; bus.addr1 = '0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [8:0] d, input logic [3:0] wm, input logic sp);
    bus.csb0 = 1'b0; bus.web0 = 1'b0; bus.addr0 = a; bus.din0 = d;
    bus.wmask0 = wm; bus.spare_wen0 = sp;
  endtask

  task automatic rd0(input logic [4:0] a);
    bus.csb0 = 1'b0; bus.web0 = 1'b1; bus.addr0 = a;
  endtask

  task automatic rd1(input logic [4:0] a);
    bus.csb1 = 1'b0; bus.addr1 = a;
  endtask

  // One clock: capture the applied request, advance, update model, check.
  task automatic cyc();
    logic       rn, r0, w0, r1, sp;
    logic [4:0] a0, a1;
    logic [8:0] d;
    logic [3:0] wm;
    rn = rst_n;
    r0 = !bus.csb0 && bus.web0;
    w0 = !bus.csb0 && !bus.web0;
    r1 = !bus.csb1;
    a0 = bus.addr0; a1 = bus.addr1; d = bus.din0; wm = bus.wmask0; sp = bus.spare_wen0;
    @(posedge clk0);
    #1;
    if (!rn) begin
      model_reset();
    end else if (fill_left > 0) begin
      fill_left--;
      ec = 1'b0;
      if (pv0) e20 = pd0;
      if (pv1) e21 = pd1;
      pv0 = 1'b0; pv1 = 1'b0;
      if (fill_left == 0) for (int i = 0; i < 32; i++) m[i] = '0;
    end else begin
      if (pv0) e20 = pd0;
      if (pv1) e21 = pd1;
      pv0 = r0; pv1 = r1;
      if (r0) begin pd0 = m[a0]; e0 = m[a0]; end
      if (r1) begin pd1 = m[a1]; e1 = m[a1]; end
      ec = w0 && r1 && (a0 == a1);
      if (w0) begin
        for (int i = 0; i < 4; i++) if (wm[i]) m[a0][2*i +: 2] = d[2*i +: 2];
        if (sp) m[a0][8] = d[8];
      end
    end
    chk_all();
  endtask

  task automatic count_fill(input string tag);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      cyc();
      n++;
    end
    chk(tag, 9'(n), 9'd32);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) m[i] = '0;
    pd0 = '0; pd1 = '0;
    idle();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_all();
    repeat (3) cyc();

    // Fill; requests during the fill must be ignored.
    rst_n = 1'b1;
    wr(5'd17, 9'h1FF, 4'hF, 1'b1);
    rd1(5'd17);
    count_fill("fill_len");
    idle();

    foreach (m[i]) if (i == 0 || i == 17 || i == 31) begin
      rd0(5'(i)); rd1(5'(i)); cyc();
      chk("init_zero_p0", bus.dout0, 9'h000);
      chk("init_zero_p1", bus.dout1, 9'h000);
      idle();
    end

    wr(5'd5, 9'h1FF, 4'b0101, 1'b0); cyc(); idle();
    rd0(5'd5); cyc(); chk("wmask_lanes", bus.dout0, 9'h033); idle();
    wr(5'd5, 9'h1FF, 4'b0000, 1'b0); cyc(); idle();
    rd0(5'd5); cyc(); chk("wmask_none", bus.dout0, 9'h033); idle();
    wr(5'd5, 9'h1FF, 4'b0000, 1'b1); cyc(); idle();
    rd0(5'd5); cyc(); chk("spare_only", bus.dout0, 9'h133); idle();

    wr(5'd3, 9'h0AA, 4'hF, 1'b1); cyc(); idle();
    wr(5'd3, 9'h155, 4'hF, 1'b1); rd1(5'd3); cyc();
    chk("rbw_dout1", bus.dout1, 9'h0AA);
    chk("coll_pulse", {8'b0, bus.collision}, 9'h001);
    idle(); rd1(5'd3); cyc();
    chk("coll_drop", {8'b0, bus.collision}, 9'h000);
    chk("rd1_new", bus.dout1, 9'h155);
    idle();
    wr(5'd3, 9'h0C3, 4'hF, 1'b1); cyc(); idle();
    rd0(5'd3); cyc(); chk("raw_p0", bus.dout0, 9'h0C3); idle();

    wr(5'd1, 9'h011, 4'hF, 1'b1); cyc();
    wr(5'd2, 9'h022, 4'hF, 1'b1); cyc();
    wr(5'd3, 9'h033, 4'hF, 1'b1); cyc();
    idle();
    rd0(5'd1); cyc();
    rd0(5'd2); cyc(); chk("pipe_a1", bus2.dout0, 9'h011);
    rd0(5'd3); cyc(); chk("pipe_a2", bus2.dout0, 9'h022);
    idle();    cyc(); chk("pipe_a3", bus2.dout0, 9'h033);

    wr(5'd9, 9'h07E, 4'hF, 1'b1); cyc(); idle();
    rd0(5'd9); cyc(); chk("hold_rd", bus.dout0, 9'h07E); idle();
    repeat (5) begin cyc(); chk("hold_desel", bus.dout0, 9'h07E); end
    wr(5'd9, 9'h1FF, 4'hF, 1'b1); cyc(); chk("hold_wr", bus.dout0, 9'h07E);
    idle();

    repeat (400) begin
      bus.csb0       = ($urandom_range(0, 3) == 0);
      bus.web0       = 1'($urandom);
      bus.addr0      = ($urandom_range(0, 9) < 7) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      bus.din0       = 9'($urandom);
      bus.wmask0     = 4'($urandom);
      bus.spare_wen0 = 1'($urandom);
      bus.csb1       = ($urandom_range(0, 3) == 0);
      bus.addr1      = ($urandom_range(0, 9) < 7) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      cyc();
    end
    idle();

    // Asynchronous reset clears the outputs at once.
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_d0", bus.dout0, 9'h000);
    chk("async_busy", {8'b0, bus.busy}, 9'h001);
    chk_all();
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (10) cyc();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_all();
    repeat (2) cyc();
    rst_n = 1'b1;
    count_fill("refill_len");
    for (int a = 0; a < 32; a++) begin
      rd0(5'(a)); rd1(5'(31 - a)); cyc();
      chk("refill_p0", bus.dout0, 9'h000);
      chk("refill_p1", bus.dout1, 9'h000);
    end
    idle();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
